serv_wb_ram: RTL and testbench

Wishbone data-memory slave that sits directly downstream of the SERV core's data-bus memory interface. It consumes the core's word-aligned address, write data, byte selects, write enable and cycle strobe, and answers each cycle with exactly one single-cycle acknowledge after a configurable number of wait states. Reads return the full 32-bit word. Writes update only the byte lanes whose select bit is set.

---
 rtl/serv_wb_ram_array.sv | 22 ++
 rtl/serv_wb_ram.sv | 65 ++++++
 tb/tb_serv_wb_ram.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serv_wb_ram_array.sv
// serv_wb_ram_array: single-port word RAM with byte write enables and registered read data
module serv_wb_ram_array #(
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdat,
  output logic [31:0]   rdat
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) rdat <= '0;
    else if (re) rdat <= mem[idx];
  end
endmodule

// File: rtl/serv_wb_ram.sv
// serv_wb_ram: wishbone data-memory slave for SERV with configurable wait states
module serv_wb_ram #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);
  localparam int AW = $clog2(DEPTH) - 2;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic [AW-1:0] idx, cur_idx;
  logic [31:0] dat, cur_dat;
  logic [3:0] sel, cur_sel;
  logic we, cur_we, go, unused;
  assign unused = &{1'b0, i_wb_adr[31:AW+2], i_wb_adr[1:0]};
  always_comb begin
    next = S_IDLE;
    if (state == S_IDLE && i_wb_cyc) next = WAIT_STATES == 0 ? S_ACK : S_WAIT;
    if (state == S_WAIT && i_wb_cyc) next = cnt == 4'd0 ? S_ACK : S_WAIT;
  end
  // With no wait states the RAM access happens on the capture edge, so the live bus is used there
  assign cur_idx = state == S_IDLE ? i_wb_adr[AW+1:2] : idx;
  assign cur_dat = state == S_IDLE ? i_wb_dat : dat;
  assign cur_sel = state == S_IDLE ? i_wb_sel : sel;
  assign cur_we  = state == S_IDLE ? i_wb_we : we;
  assign go = next == S_ACK && !i_rst;
  assign o_wb_ack = state == S_ACK;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= next;
      if (state == S_IDLE && i_wb_cyc) cnt <= CNT_LOAD;
      else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (state == S_IDLE && i_wb_cyc) begin
      idx <= i_wb_adr[AW+1:2];
      dat <= i_wb_dat;
      sel <= i_wb_sel;
      we <= i_wb_we;
    end
  end
  serv_wb_ram_array #(.AW(AW)) u_array (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .we(go && cur_we ? cur_sel : 4'b0000),
    .re(go && !cur_we),
    .idx(cur_idx),
    .wdat(cur_dat),
    .rdat(o_wb_rdt)
  );
endmodule

// File: tb/tb_serv_wb_ram.sv
// tb_serv_wb_ram: table, hand-written and random checks of two instances (0 and 3 wait states)
module tb_serv_wb_ram;
  logic clk = 0, rst = 0;
  logic [31:0] adr_s [2], dat_s [2], rdt [2];
  logic [3:0] sel_s [2];
  logic we_s [2], cyc [2], ack [2];
  logic [7:0] ref_b [2][256];
  logic [31:0] last_rd [2];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  serv_wb_ram #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr_s[0]), .i_wb_dat(dat_s[0]), .i_wb_sel(sel_s[0]),
    .i_wb_we(we_s[0]), .i_wb_cyc(cyc[0]), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]));
  serv_wb_ram #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr_s[1]), .i_wb_dat(dat_s[1]), .i_wb_sel(sel_s[1]),
    .i_wb_we(we_s[1]), .i_wb_cyc(cyc[1]), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]));

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int d, input logic [31:0] adr);
    int b = int'(adr[7:2]) * 4;
    return {ref_b[d][b+3], ref_b[d][b+2], ref_b[d][b+1], ref_b[d][b]};
  endfunction

  task automatic ref_wr(input int d, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int b = int'(adr[7:2]) * 4;
    for (int n = 0; n < 4; n++)
      if (sel[n]) ref_b[d][b+n] = dat[8*n +: 8];
  endtask

  task automatic txn(input int d, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd);
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    cyc[d] = 1; we_s[d] = we; adr_s[d] = adr; dat_s[d] = dat; sel_s[d] = sel;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[d]) got = 1;
      else if (lat == 1 && d == 1) begin
        adr_s[d] = $urandom; dat_s[d] = $urandom; sel_s[d] = 4'($urandom); we_s[d] = 1'($urandom);
      end
    end
    chk(d == 0 ? "latency_ws0" : "latency_ws3", 32'(lat), d == 0 ? 32'd1 : 32'd4);
    rd = rdt[d];
    cyc[d] = 0; adr_s[d] = $urandom; dat_s[d] = $urandom; sel_s[d] = 4'($urandom); we_s[d] = 1'($urandom);
    @(posedge clk); #1;
    chk("ack_single_pulse", 32'(ack[d]), 32'd0);
    if (we) begin
      chk("rdt_hold_on_write", rd, last_rd[d]);
      ref_wr(d, adr, dat, sel);
    end else begin
      chk("read_data", rd, ref_rd(d, adr));
      last_rd[d] = rd;
    end
  endtask

  initial begin
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1; we_s[d] = 1; adr_s[d] = 32'h10; dat_s[d] = 32'hFFFFFFFF; sel_s[d] = 4'hF;
      last_rd[d] = 0;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; cyc[0] = 0; cyc[1] = 0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", 32'(ack[d]), 32'd0);
      chk("reset_rdt", rdt[d], 32'd0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk("post_reset_ack", 32'(ack[d]), 32'd0);

    for (int w = 0; w < 64; w++)
      for (int d = 0; d < 2; d++) txn(d, 1, 32'(w * 4), $urandom, 4'hF, rd);

    tbl[0] = '{1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0};
    tbl[1] = '{0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF};
    tbl[2] = '{1, 32'h20,  32'h11223344, 4'b1111, 32'h0};
    tbl[3] = '{1, 32'h20,  32'h0000AA00, 4'b0010, 32'h0};
    tbl[4] = '{0, 32'h20,  32'h0,        4'b0001, 32'h1122AA44};
    tbl[5] = '{1, 32'h20,  32'hBBBB0000, 4'b1100, 32'h0};
    tbl[6] = '{0, 32'h23,  32'h0,        4'b0000, 32'hBBBBAA44};
    tbl[7] = '{1, 32'h104, 32'hCAFEF00D, 4'b1111, 32'h0};
    tbl[8] = '{0, 32'h4,   32'h0,        4'b1000, 32'hCAFEF00D};
    for (int i = 0; i < 9; i++) begin
      txn(0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
      if (!tbl[i].we) chk("table_read", rd, tbl[i].exp);
    end

    txn(1, 1, 32'h30, 32'h0, 4'hF, rd);
    txn(1, 0, 32'h10, 32'h0, 4'hF, rd);
    @(negedge clk);
    cyc[1] = 1; we_s[1] = 1; adr_s[1] = 32'h30; dat_s[1] = 32'h55555555; sel_s[1] = 4'hF;
    @(posedge clk); #1;
    cyc[1] = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", 32'(ack[1]), 32'd0);
    end
    txn(1, 0, 32'h30, 32'h0, 4'hF, rd);
    chk("abort_no_write", rd, 32'h0);

    txn(1, 1, 32'h38, 32'h0, 4'hF, rd);
    @(negedge clk);
    cyc[1] = 1; we_s[1] = 1; adr_s[1] = 32'h38; dat_s[1] = 32'hFFFFFFFF; sel_s[1] = 4'hF;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; cyc[1] = 0;
    chk("midreset_rdt0", rdt[0], 32'h0);
    chk("midreset_rdt3", rdt[1], 32'h0);
    last_rd[0] = 0; last_rd[1] = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midreset_no_ack", 32'(ack[1]), 32'd0);
    end
    txn(1, 0, 32'h38, 32'h0, 4'hF, rd);
    chk("midreset_no_write", rd, 32'h0);

    for (int i = 0; i < 200; i++)
      txn(i % 2, 1'($urandom), $urandom, $urandom, 4'($urandom), rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
